// File: rtl/ap_frame_pkg.sv
// ap_frame_pkg: definitions shared by the frame checker slice.
//   state_e      frame parser states
//   LEN_LSB/TAG_LSB      header field offsets (32-bit fields)
//   TRL_*        trailer field offsets
//   xor_fold128  folds a 128-bit word into 32 bits by XOR of its four lanes
package ap_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_e;

    localparam int FIELD_W = 32;

    // Header layout: bits [127:64] are opaque and forwarded untouched.
    localparam int LEN_LSB = 0;
    localparam int TAG_LSB = 32;

    // Trailer layout: {oversize, 15'h0, seq, csum, tag, count}.
    localparam int TRL_COUNT_LSB = 0;
    localparam int TRL_TAG_LSB   = 32;
    localparam int TRL_CSUM_LSB  = 64;
    localparam int TRL_SEQ_LSB   = 96;
    localparam int TRL_SEQ_W     = 16;
    localparam int TRL_OVS_BIT   = 127;

    function automatic logic [31:0] xor_fold128(input logic [127:0] w);
        xor_fold128 = w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
    endfunction

endpackage

// File: rtl/ap_fifo_frame_checker_if.sv
// ap_fifo_frame_checker_if: the ap_fifo channel pair seen by the checker.
//   in_r_dout / in_r_empty_n / in_r_read    to-function FIFO read port
//   out_r_din / out_r_write / out_r_full    from-function FIFO write port
// Modport slave is the checker side; master is the shell side.
interface ap_fifo_frame_checker_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] in_r_dout;
    logic              in_r_empty_n;
    logic              in_r_read;
    logic [DATA_W-1:0] out_r_din;
    logic              out_r_write;
    logic              out_r_full;

    modport master (
        output in_r_dout, in_r_empty_n, out_r_full,
        input  in_r_read, out_r_din, out_r_write
    );

    modport slave (
        input  in_r_dout, in_r_empty_n, out_r_full,
        output in_r_read, out_r_din, out_r_write
    );
endinterface

// File: rtl/ap_frame_trailer_gen.sv
// ap_frame_trailer_gen: holds the per-frame trailer fields and builds the
// trailer word.
//   ip_clk, rst        clock, synchronous active-high reset
//   hdr_load           header accepted: capture tag/count/oversize, clear csum
//   hdr_tag/count/oversize  values captured on hdr_load
//   pay_acc, pay_word  payload word accepted: fold it into the checksum
//   trl_write          trailer written: advance the sequence number
//   trailer            assembled trailer word
//   oversize           oversize flag of the current frame
module ap_frame_trailer_gen
    import ap_frame_pkg::*;
(
    input  logic         ip_clk,
    input  logic         rst,
    input  logic         hdr_load,
    input  logic [31:0]  hdr_tag,
    input  logic [31:0]  hdr_count,
    input  logic         hdr_oversize,
    input  logic         pay_acc,
    input  logic [127:0] pay_word,
    input  logic         trl_write,
    output logic [127:0] trailer,
    output logic         oversize
);

    logic [31:0]          tag_r;
    logic [31:0]          count_r;
    logic [31:0]          csum_r;
    logic [TRL_SEQ_W-1:0] seq_r;
    logic                 oversize_r;
    logic [127:0]         trailer_s;

    // Frame fields: captured at the header, checksum folded per payload word, seq bumped per trailer
    always_ff @(posedge ip_clk) begin
        if (rst) begin
            tag_r      <= 32'h0;
            count_r    <= 32'h0;
            csum_r     <= 32'h0;
            seq_r      <= 16'h0;
            oversize_r <= 1'b0;
        end else begin
            if (hdr_load) begin
                tag_r      <= hdr_tag;
                count_r    <= hdr_count;
                oversize_r <= hdr_oversize;
                csum_r     <= 32'h0;
            end else if (pay_acc) begin
                csum_r <= csum_r ^ xor_fold128(pay_word);
            end
            if (trl_write) begin
                seq_r <= seq_r + 16'd1;
            end
        end
    end

    // Trailer word assembly; bits [126:112] stay zero
    always_comb begin
        trailer_s = 128'h0;
        trailer_s[TRL_COUNT_LSB +: FIELD_W]  = count_r;
        trailer_s[TRL_TAG_LSB +: FIELD_W]    = tag_r;
        trailer_s[TRL_CSUM_LSB +: FIELD_W]   = csum_r;
        trailer_s[TRL_SEQ_LSB +: TRL_SEQ_W]  = seq_r;
        trailer_s[TRL_OVS_BIT]               = oversize_r;
    end

    assign trailer  = trailer_s;
    assign oversize = oversize_r;

endmodule

// File: rtl/ap_fifo_frame_checker.sv
// ap_fifo_frame_checker: forwards header-framed packets from the to-function
// FIFO to the from-function FIFO with zero latency and appends one trailer
// word per frame {oversize, 15'h0, seq, csum, tag, count}.
//   ip_clk, rst     clock, synchronous active-high reset
//   en              allows a new frame to start (sampled in IDLE and at trailer exit)
//   fifo            ap_fifo channel pair (slave side)
//   busy            state is not IDLE
//   frames_done     trailers written, wraps modulo 2^32
//   oversize_seen   sticky: some frame announced more than MAX_LEN words
module ap_fifo_frame_checker
    import ap_frame_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int LEN_W   = 32,
    parameter int MAX_LEN = 65535
) (
    input  logic                        ip_clk,
    input  logic                        rst,
    input  logic                        en,
    ap_fifo_frame_checker_if.slave      fifo,
    output logic                        busy,
    output logic [31:0]                 frames_done,
    output logic                        oversize_seen
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_e             state_r;
    state_e             state_next_s;
    logic [LEN_W-1:0]   remaining_r;
    logic [LEN_W-1:0]   hdr_len_s;
    logic [LEN_W-1:0]   len_clip_s;
    logic               hdr_oversize_s;
    logic [31:0]        hdr_tag_s;
    logic [31:0]        hdr_count_s;
    logic               xfer_s;
    logic               hdr_take_s;
    logic               pay_take_s;
    logic               trl_write_s;
    logic               trl_oversize_s;
    logic [DATA_W-1:0]  trailer_s;
    logic [31:0]        frames_done_r;
    logic               oversize_seen_r;

    assign xfer_s         = fifo.in_r_empty_n & ~fifo.out_r_full;
    assign hdr_len_s      = fifo.in_r_dout[LEN_LSB +: LEN_W];
    assign hdr_tag_s      = fifo.in_r_dout[TAG_LSB +: FIELD_W];
    assign hdr_oversize_s = (hdr_len_s > MAX_LEN_C);
    // Oversize frames are cut at MAX_LEN; the surplus words are parsed as the next header.
    assign len_clip_s     = hdr_oversize_s ? MAX_LEN_C : hdr_len_s;
    assign hdr_count_s    = FIELD_W'(len_clip_s);
    assign hdr_take_s     = (state_r == HDR) & xfer_s;
    assign pay_take_s     = (state_r == PAY) & xfer_s;
    assign trl_write_s    = (state_r == TRL) & ~fifo.out_r_full;

    ap_frame_trailer_gen u_trailer (
        .ip_clk       (ip_clk),
        .rst          (rst),
        .hdr_load     (hdr_take_s),
        .hdr_tag      (hdr_tag_s),
        .hdr_count    (hdr_count_s),
        .hdr_oversize (hdr_oversize_s),
        .pay_acc      (pay_take_s),
        .pay_word     (fifo.in_r_dout),
        .trl_write    (trl_write_s),
        .trailer      (trailer_s),
        .oversize     (trl_oversize_s)
    );

    // State register, payload countdown and frame statistics
    always_ff @(posedge ip_clk) begin
        if (rst) begin
            state_r         <= IDLE;
            remaining_r     <= {LEN_W{1'b0}};
            frames_done_r   <= 32'h0;
            oversize_seen_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (hdr_take_s) begin
                remaining_r <= len_clip_s;
            end else if (pay_take_s) begin
                remaining_r <= remaining_r - LEN_W'(1);
            end
            if (trl_write_s) begin
                frames_done_r   <= frames_done_r + 32'd1;
                oversize_seen_r <= oversize_seen_r | trl_oversize_s;
            end
        end
    end

    // Next-state logic; en only matters in IDLE and when leaving TRL
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_next_s = HDR;
                else    state_next_s = IDLE;
            end
            HDR: begin
                if (xfer_s) begin
                    if (len_clip_s == {LEN_W{1'b0}}) state_next_s = TRL;
                    else                             state_next_s = PAY;
                end else begin
                    state_next_s = HDR;
                end
            end
            PAY: begin
                if (xfer_s && (remaining_r == LEN_W'(1))) state_next_s = TRL;
                else                                       state_next_s = PAY;
            end
            TRL: begin
                if (!fifo.out_r_full) begin
                    if (en) state_next_s = HDR;
                    else    state_next_s = IDLE;
                end else begin
                    state_next_s = TRL;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FIFO strobes and output word: pass-through in HDR/PAY, trailer in TRL
    always_comb begin
        fifo.in_r_read   = 1'b0;
        fifo.out_r_write = 1'b0;
        fifo.out_r_din   = {DATA_W{1'b0}};
        case (state_r)
            HDR, PAY: begin
                fifo.in_r_read   = xfer_s;
                fifo.out_r_write = xfer_s;
                fifo.out_r_din   = fifo.in_r_dout;
            end
            TRL: begin
                fifo.out_r_write = ~fifo.out_r_full;
                fifo.out_r_din   = trailer_s;
            end
            default: begin
                fifo.in_r_read   = 1'b0;
                fifo.out_r_write = 1'b0;
            end
        endcase
    end

    assign busy          = (state_r != IDLE);
    assign frames_done   = frames_done_r;
    assign oversize_seen = oversize_seen_r;

endmodule

// File: tb/tb_ap_fifo_frame_checker.sv
// Bench for ap_fifo_frame_checker: a table of frame records, randomized
// frames with random backpressure, and hand sequences for en drop and
// reset mid-frame. Expected output words come from a stream-level model
// that parses the pushed input words into frames.
module tb_ap_fifo_frame_checker;

    localparam int MAX_L = 10;

    logic        ip_clk;
    logic        rst;
    logic        en;
    logic        busy;
    logic [31:0] frames_done;
    logic        oversize_seen;

    ap_fifo_frame_checker_if ifc ();

    ap_fifo_frame_checker #(.DATA_W(128), .LEN_W(32), .MAX_LEN(MAX_L)) dut (
        .ip_clk        (ip_clk),
        .rst           (rst),
        .en            (en),
        .fifo          (ifc),
        .busy          (busy),
        .frames_done   (frames_done),
        .oversize_seen (oversize_seen)
    );

    initial begin
        ip_clk = 1'b0;
        forever #5 ip_clk = ~ip_clk;
    end

    typedef struct {
        logic [31:0] len;
        logic [31:0] tag;
        int          npay;
        int          full_mode;
        int          empty_at;
        int          exp_writes;
        logic [31:0] exp_count;
        logic        exp_ovs;
        logic        exp_seen;
    } row_t;

    row_t         rows [7];
    int           total = 0;
    int           bad = 0;
    logic [127:0] in_q [$];
    logic [127:0] exp_q [$];
    logic [127:0] hist [$];
    int           mdl_pos = 0;
    logic [15:0]  m_seq = 16'h0;
    logic [31:0]  m_frames = 32'h0;
    logic         m_ovs = 1'b0;
    int           full_mode = 0;
    int           empty_hold = 0;
    int           cur_empty_at = -1;
    bit           rand_empty = 1'b0;
    int           cyc = 0;
    int           n_wr = 0;
    int           n_rd = 0;
    bit           row_first = 1'b0;
    int           first_wr_cyc = 0;
    int           last_wr_cyc = 0;
    logic [127:0] last_wr = 128'h0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Stream model: parse whole frames out of every word pushed so far.
    function automatic void model_advance();
        logic [127:0] h;
        logic [127:0] w;
        logic [31:0]  len;
        logic [31:0]  n;
        logic [31:0]  csum;
        logic         ovs;
        bit           more;
        more = 1'b1;
        while (more) begin
            if (mdl_pos >= hist.size()) begin
                more = 1'b0;
            end else begin
                h   = hist[mdl_pos];
                len = h[31:0];
                ovs = (len > 32'(MAX_L));
                n   = ovs ? 32'(MAX_L) : len;
                if (mdl_pos + 1 + int'(n) > hist.size()) begin
                    more = 1'b0;
                end else begin
                    exp_q.push_back(h);
                    csum = 32'h0;
                    for (int i = 0; i < int'(n); i++) begin
                        w = hist[mdl_pos + 1 + i];
                        exp_q.push_back(w);
                        for (int l = 0; l < 4; l++) csum = csum ^ w[32*l +: 32];
                    end
                    exp_q.push_back({ovs, 15'h0, m_seq, csum, h[63:32], n});
                    m_seq    = m_seq + 16'd1;
                    m_frames = m_frames + 32'd1;
                    m_ovs    = m_ovs | ovs;
                    mdl_pos  = mdl_pos + 1 + int'(n);
                end
            end
        end
    endfunction

    task automatic push_pay(input int npay);
        logic [127:0] w;
        for (int i = 0; i < npay; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            in_q.push_back(w);
            hist.push_back(w);
        end
        model_advance();
    endtask

    task automatic push_frame(input logic [31:0] len, input logic [31:0] tag, input int npay);
        logic [127:0] w;
        w = {$urandom, $urandom, tag, len};
        in_q.push_back(w);
        hist.push_back(w);
        push_pay(npay);
    endtask

    // One clock: drive shell-side inputs after the edge, return after the monitor sampled.
    task automatic step();
        bit avail;
        @(posedge ip_clk);
        #1;
        cyc++;
        case (full_mode)
            0:       ifc.out_r_full = 1'b0;
            1:       ifc.out_r_full = ~ifc.out_r_full;
            3:       ifc.out_r_full = 1'b1;
            default: ifc.out_r_full = ($urandom_range(0, 3) == 0);
        endcase
        if (empty_hold > 0) begin
            avail = 1'b0;
            empty_hold--;
        end else if (rand_empty) begin
            avail = ($urandom_range(0, 3) != 0);
        end else begin
            avail = 1'b1;
        end
        if (avail && in_q.size() > 0) begin
            ifc.in_r_empty_n = 1'b1;
            ifc.in_r_dout    = in_q[0];
        end else begin
            ifc.in_r_empty_n = 1'b0;
            ifc.in_r_dout    = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge ip_clk);
        #1;
    endtask

    task automatic drain(input int limit, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && k < limit) begin
            if (k == cur_empty_at) empty_hold = 3;
            step();
            k++;
        end
        check({name, "_drain"}, 128'((exp_q.size() == 0) && (in_q.size() == 0)), 128'd1);
    endtask

    // Shell-side monitor: consume read words, compare written words with the model.
    always @(negedge ip_clk) begin
        if (ifc.in_r_read) begin
            check("read_when_empty", 128'(ifc.in_r_empty_n), 128'd1);
            if (in_q.size() > 0) void'(in_q.pop_front());
            n_rd++;
        end
        if (ifc.out_r_write) begin
            check("write_when_full", 128'(ifc.out_r_full), 128'd0);
            check("write_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check("out_word", ifc.out_r_din, exp_q.pop_front());
            n_wr++;
            if (row_first) begin
                first_wr_cyc = cyc;
                row_first    = 1'b0;
            end
            last_wr_cyc = cyc;
            last_wr     = ifc.out_r_din;
        end
    end

    initial begin
        int wr0;
        int rd0;
        int exp_wr;
        int k;
        logic [31:0] len;
        int n;

        //            len     tag           npay fm ea  wr  count ovs seen
        rows[0] = '{32'd3,  32'hABCD0001, 3,   0, -1, 5,  32'd3,  1'b0, 1'b0};
        rows[1] = '{32'd0,  32'h00000007, 0,   0, -1, 2,  32'd0,  1'b0, 1'b0};
        rows[2] = '{32'd4,  32'h00000044, 4,   1,  2, 6,  32'd4,  1'b0, 1'b0};
        rows[3] = '{32'd13, 32'h00000BAD, 10,  0, -1, 12, 32'd10, 1'b1, 1'b1};
        rows[4] = '{32'd10, 32'h0000000A, 10,  0, -1, 12, 32'd10, 1'b0, 1'b1};
        rows[5] = '{32'd11, 32'h0000000B, 10,  1, -1, 12, 32'd10, 1'b1, 1'b1};
        rows[6] = '{32'd1,  32'h00000001, 1,   0,  0, 3,  32'd1,  1'b0, 1'b1};

        rst = 1'b1;
        en  = 1'b0;
        ifc.out_r_full   = 1'b0;
        ifc.in_r_empty_n = 1'b0;
        ifc.in_r_dout    = 128'h0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_write", 128'(ifc.out_r_write), 128'd0);
        check("rst_read", 128'(ifc.in_r_read), 128'd0);
        check("rst_frames_done", 128'(frames_done), 128'd0);
        check("rst_oversize_seen", 128'(oversize_seen), 128'd0);

        // Table-driven frames
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            full_mode    = rows[i].full_mode;
            cur_empty_at = rows[i].empty_at;
            wr0          = n_wr;
            row_first    = 1'b1;
            push_frame(rows[i].len, rows[i].tag, rows[i].npay);
            drain(300, "row");
            full_mode    = 0;
            cur_empty_at = -1;
            step();
            check("row_writes", 128'(n_wr - wr0), 128'(rows[i].exp_writes));
            check("row_trl_count", 128'(last_wr[31:0]), 128'(rows[i].exp_count));
            check("row_trl_tag", 128'(last_wr[63:32]), 128'(rows[i].tag));
            check("row_trl_seq", 128'(last_wr[111:96]), 128'(i));
            check("row_trl_ovs", 128'(last_wr[127]), 128'(rows[i].exp_ovs));
            check("row_frames_done", 128'(frames_done), 128'(i + 1));
            check("row_oversize_seen", 128'(oversize_seen), 128'(rows[i].exp_seen));
            if (rows[i].full_mode == 0 && rows[i].empty_at < 0)
                check("row_span", 128'(last_wr_cyc - first_wr_cyc + 1), 128'(rows[i].exp_writes));
        end

        // Randomized frames under random backpressure on both sides
        full_mode  = 2;
        rand_empty = 1'b1;
        wr0        = n_wr;
        exp_wr     = 0;
        for (int f = 0; f < 40; f++) begin
            len = 32'($urandom_range(0, 13));
            n   = (len > 32'(MAX_L)) ? MAX_L : int'(len);
            push_frame(len, $urandom, n);
            exp_wr += n + 2;
        end
        drain(6000, "rand");
        full_mode  = 0;
        rand_empty = 1'b0;
        step();
        check("rand_writes", 128'(n_wr - wr0), 128'(exp_wr));
        check("rand_frames_done", 128'(frames_done), 128'(m_frames));
        check("rand_oversize_seen", 128'(oversize_seen), 128'(m_ovs));

        // en dropped mid-frame: the frame still completes, then the block idles
        wr0 = n_wr;
        push_frame(32'd4, 32'h0000E0E0, 4);
        step();
        step();
        en = 1'b0;
        drain(100, "en_drop");
        step();
        check("en_drop_writes", 128'(n_wr - wr0), 128'd6);
        check("en_drop_idle", 128'(busy), 128'd0);
        check("en_drop_trl_count", 128'(last_wr[31:0]), 128'd4);

        // en low in IDLE with a word waiting: nothing is read
        push_frame(32'd8, 32'h00008888, 0);
        rd0 = n_rd;
        repeat (5) step();
        check("en_low_reads", 128'(n_rd - rd0), 128'd0);
        check("en_low_busy", 128'(busy), 128'd0);

        // Reset after two payload words of a len=8 frame
        push_pay(8);
        en  = 1'b1;
        wr0 = n_wr;
        k   = 0;
        while ((n_wr - wr0) < 3 && k < 50) begin
            step();
            k++;
        end
        check("pre_rst_writes", 128'(n_wr - wr0), 128'd3);
        rst       = 1'b1;
        full_mode = 3;
        step();
        rst = 1'b0;
        check("mid_rst_write", 128'(ifc.out_r_write), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_frames_done", 128'(frames_done), 128'd0);
        check("mid_rst_oversize_seen", 128'(oversize_seen), 128'd0);
        in_q.delete();
        exp_q.delete();
        hist.delete();
        mdl_pos   = 0;
        m_seq     = 16'h0;
        m_frames  = 32'h0;
        m_ovs     = 1'b0;
        full_mode = 0;
        push_frame(32'd1, 32'h00001111, 1);
        drain(100, "post_rst");
        step();
        check("post_rst_seq", 128'(last_wr[111:96]), 128'd0);
        check("post_rst_count", 128'(last_wr[31:0]), 128'd1);
        check("post_rst_frames_done", 128'(frames_done), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
